piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out stage. Sits directly upstream of the 4-bit SIPO shift register.
//   Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled
//   cycle, MSB first, with frame strobes. A downstream SIPO clocked with enable
//   (dout_valid & shift_en) holds the original word after the last bit.
// PARAMETERS
//   WIDTH      4   word width in bits; legal range >= 2
//   MSB_FIRST  1   1: emit bit WIDTH-1 first; 0: emit bit 0 first
//   CNT_W      16  width of the frame_cnt statistics counter
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-low reset
//   load_data    in   WIDTH   parallel word to serialize
//   load_valid   in   1       load_data valid
//   load_ready   out  1       serializer can accept a word this cycle
//   shift_en     in   1       downstream accepts current bit at next edge; 0 = stall
//   dout         out  1       current serial bit
//   dout_valid   out  1       dout carries a frame bit
//   frame_start  out  1       dout is first bit of a frame
//   frame_end    out  1       dout is last bit of a frame
//   frame_cnt    out  CNT_W   frames fully shifted out since reset; wraps
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, shreg=0, bit_cnt=0, frame_cnt=0.
//     Outputs: dout=0, dout_valid=0, frame_start=0, frame_end=0, load_ready=1.
//   - States:
//     IDLE:  no frame in progress.
//     SHIFT: a frame is being emitted. bit_cnt indexes the current bit, 0..WIDTH-1.
//   - load_ready = (state==IDLE) | (state==SHIFT & shift_en & bit_cnt==WIDTH-1). Combinational.
//   - Accept: load_valid & load_ready at an edge.
//     That edge: shreg<=load_data, bit_cnt<=0, state<=SHIFT.
//     First bit is valid on dout in the following cycle (1-cycle latency).
//   - dout = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0) while in SHIFT; 0 in IDLE.
//   - dout_valid = (state==SHIFT). frame_start = dout_valid & bit_cnt==0.
//     frame_end = dout_valid & bit_cnt==WIDTH-1.
//   - Advance (SHIFT & shift_en & bit_cnt<WIDTH-1):
//     shreg shifts toward the output end, zero filled; bit_cnt++.
//   - Stall (SHIFT & ~shift_en): shreg, bit_cnt, state and all outputs hold. A stall can
//     last indefinitely.
//   - Last bit (SHIFT & shift_en & bit_cnt==WIDTH-1): frame_cnt++ (wraps at 2^CNT_W).
//     Then, if load_valid: reload as in Accept, so frames run back-to-back with no bubble.
//     Otherwise state<=IDLE.
//   - load_valid while load_ready=0: ignored. Upstream holds load_data and load_valid
//     until the handshake completes.
//   - load_data may change while not accepted. It is sampled only on the accepting edge.
//   - Reset mid-frame: the partial frame is discarded and frame_cnt is not incremented.
//     After rst deasserts, the first valid bit appears no earlier than one cycle after the
//     next accept.
//   - shift_en is ignored in IDLE. frame_start and frame_end are never both high
//     (WIDTH>=2).
// STRUCTURE
//   - Shared include serdes_defs.vh: state encodings SER_IDLE=1'b0, SER_SHIFT=1'b1,
//     and the minimum-WIDTH check constant.
//   - Sub-module serializer_bit_counter: $clog2(WIDTH)-bit counter with clear, enable
//     and terminal-count flag (bit_cnt==WIDTH-1). Reused later by the receive side.
//   - Top level holds the state register, shreg, frame_cnt and the handshake logic.
// TESTING
//   1. Reset, then load 4'b1011 with shift_en=1.
//      -> dout=1,0,1,1 on 4 consecutive cycles; frame_start on bit 0, frame_end on bit 3.
//      The SIPO captures 4'b1011. frame_cnt=1.
//   2. Back-to-back: load_valid held high with 4'hA then 4'h5.
//      -> 8 contiguous valid bits 1010_0101 with no idle cycle; load_ready high only on
//      the last-bit cycles; frame_cnt=2.
//   3. Load 4'hC, drop shift_en for 3 cycles after bit 1.
//      -> dout holds at 1 with dout_valid=1 for the stall; the sequence resumes 0,0;
//      total 7 valid cycles.
//   4. load_valid asserted with 4'hF during bit 1 of a 4'h0 frame.
//      -> ignored until the last-bit cycle, then accepted; output 0000 then 1111.
//   5. Assert rst during bit 2 of 4'h9.
//      -> dout_valid drops immediately; frame_cnt stays 0.
//      After release, load 4'h6 -> 0,1,1,0.
//   6. MSB_FIRST=0, WIDTH=8, load 8'h81 -> bits 1,0,0,0,0,0,0,1.
//      Also run frame_cnt with CNT_W=2 for 5 frames -> wraps to 1.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the serializer datapath and its bit counter.
package piso_serializer_pkg;

  // Frame state: idle, or a frame is on the serial output
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // A frame needs at least two bits so frame_start and frame_end never coincide
  localparam int unsigned SER_MIN_WIDTH = 2;

  // Width of the bit-index counter for a frame of w bits
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Bit-index counter with clear, enable and terminal-count flag (index == WIDTH-1).
module serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over enable so a reload restarts the frame at bit 0
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a word over valid/ready and emits it one bit
// per enabled cycle with frame strobes; back-to-back frames run without a bubble.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             shift_en_i,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  localparam int unsigned CW      = cnt_width(WIDTH);
  localparam int unsigned OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  if (WIDTH < SER_MIN_WIDTH) begin : g_width_chk
    $error("piso_serializer: WIDTH must be at least 2");
  end

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]    bit_cnt;
  logic             bit_tc;
  logic             cnt_clr;
  logic             cnt_en;
  logic             ready;
  logic [WIDTH-1:0] shreg_shifted;

  // Bit index within the current frame
  serializer_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (bit_cnt),
    .tc_o   (bit_tc)
  );

  // Move the next bit onto the output end, zero filling behind it
  always_comb begin
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Next state, handshake and datapath control
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    frame_cnt_d = frame_cnt_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    ready       = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        ready = 1'b1;
        if (load_valid_i) begin
          shreg_d = load_data_i;
          cnt_clr = 1'b1;
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (shift_en_i) begin
          if (bit_tc) begin
            // Last bit leaves this edge; a waiting word follows with no gap
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            ready       = 1'b1;
            if (load_valid_i) begin
              shreg_d = load_data_i;
              cnt_clr = 1'b1;
            end else begin
              state_d = SER_IDLE;
            end
          end else begin
            shreg_d = shreg_shifted;
            cnt_en  = 1'b1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  // State, shift register and frame statistics
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SER_IDLE;
      shreg_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign load_ready_o  = ready;
  assign dout_valid_o  = (state_q == SER_SHIFT);
  assign dout_o        = dout_valid_o & shreg_q[OUT_IDX];
  assign frame_start_o = dout_valid_o & (bit_cnt == '0);
  assign frame_end_o   = dout_valid_o & bit_tc;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializer instances (4-bit MSB-first, 8-bit LSB-first with a
// 2-bit frame counter) driven by directed and random stimulus.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } exp_t;

  logic        clk;
  logic        rst_ni;
  logic [7:0]  ld [2];
  logic        lv [2];
  logic        se [2];
  logic        lr [2];
  logic        dv [2];
  logic        dout [2];
  logic        fs [2];
  logic        fe [2];
  logic [15:0] fc0;
  logic [1:0]  fc1;
  logic [31:0] fcw [2];

  int unsigned wd   [2] = '{4, 8};
  bit          msbf [2] = '{1'b1, 1'b0};
  int unsigned cntw [2] = '{16, 2};

  exp_t        sbq [2][$];
  logic [31:0] wq  [2][$];
  int unsigned fcm  [2];
  logic [31:0] sipo [2];
  bit          rand_se [2];

  int n_vec = 0;
  int n_err = 0;

  assign fcw[0] = 32'(fc0);
  assign fcw[1] = 32'(fc1);

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .load_data_i   (ld[0][3:0]),
    .load_valid_i  (lv[0]),
    .load_ready_o  (lr[0]),
    .shift_en_i    (se[0]),
    .dout_o        (dout[0]),
    .dout_valid_o  (dv[0]),
    .frame_start_o (fs[0]),
    .frame_end_o   (fe[0]),
    .frame_cnt_o   (fc0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(2)) dut8 (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .load_data_i   (ld[1]),
    .load_valid_i  (lv[1]),
    .load_ready_o  (lr[1]),
    .shift_en_i    (se[1]),
    .dout_o        (dout[1]),
    .dout_valid_o  (dv[1]),
    .frame_start_o (fs[1]),
    .frame_end_o   (fe[1]),
    .frame_cnt_o   (fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Monitor: compare every cycle against the reference frame queue
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t        e;
      bit          v;
      logic [31:0] mask;
      logic [31:0] w;
      mask = (32'd1 << wd[k]) - 32'd1;
      if (!rst_ni) begin
        sbq[k].delete();
        wq[k].delete();
        fcm[k]  = 0;
        sipo[k] = '0;
      end
      v = (sbq[k].size() != 0);
      e = v ? sbq[k][0] : '0;
      chk("dout_valid", k, 32'(dv[k]), 32'(v));
      chk("dout", k, 32'(dout[k]), 32'(e.b));
      chk("frame_start", k, 32'(fs[k]), 32'(e.s));
      chk("frame_end", k, 32'(fe[k]), 32'(e.e));
      chk("frame_cnt", k, fcw[k], fcm[k] % (32'd1 << cntw[k]));
      chk("load_ready", k, 32'(lr[k]), 32'(!v || (se[k] && e.e)));
      if (rst_ni && v && se[k]) begin
        void'(sbq[k].pop_front());
        if (msbf[k]) sipo[k] = ((sipo[k] << 1) | 32'(e.b)) & mask;
        else         sipo[k] = (sipo[k] >> 1) | (32'(e.b) << (wd[k] - 1));
        if (e.e) begin
          fcm[k]++;
          chk("sipo_word", k, sipo[k], wq[k].pop_front());
        end
      end
      if (rst_ni && lv[k] && lr[k]) begin
        w = 32'(ld[k]) & mask;
        wq[k].push_back(w);
        for (int i = 0; i < int'(wd[k]); i++) begin
          exp_t x;
          x.b = w[msbf[k] ? int'(wd[k]) - 1 - i : i];
          x.s = (i == 0);
          x.e = (i == int'(wd[k]) - 1);
          sbq[k].push_back(x);
        end
      end
    end
  end

  // Random shift_en for instances in random mode
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rand_se[k]) se[k] = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int k, input logic [7:0] w, input bit keep);
    int n;
    ld[k] = w;
    lv[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lr[k] && n < 500);
    if (!lr[k]) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout[%0d] at %0t: got no load_ready expected accept", k, $time);
    end
    @(posedge clk);
    #1;
    if (!keep) lv[k] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni     = 1'b0;
    rand_se[0] = 1'b0;
    rand_se[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ld[k] = '0;
      lv[k] = 1'b0;
      se[k] = 1'b1;
    end
    cycles(3);
    rst_ni = 1'b1;
    cycles(1);

    // Single frame 1011
    send(0, 8'h0B, 1'b0);
    cycles(6);

    // Back-to-back A then 5
    send(0, 8'h0A, 1'b1);
    send(0, 8'h05, 1'b0);
    cycles(10);

    // Stall three cycles on bit 1 of C
    send(0, 8'h0C, 1'b0);
    cycles(1);
    se[0] = 1'b0;
    cycles(3);
    se[0] = 1'b1;
    cycles(6);

    // Load offered mid-frame waits for the last-bit cycle
    send(0, 8'h00, 1'b0);
    cycles(1);
    send(0, 8'h0F, 1'b0);
    cycles(6);

    // Reset during bit 2 of 9, then 6
    send(0, 8'h09, 1'b0);
    cycles(2);
    rst_ni = 1'b0;
    cycles(2);
    rst_ni = 1'b1;
    cycles(1);
    send(0, 8'h06, 1'b0);
    cycles(6);

    // 8-bit LSB-first frame, then frame counter wrap on the 2-bit counter
    send(1, 8'h81, 1'b0);
    cycles(10);
    for (int i = 0; i < 5; i++) send(1, 8'($urandom), i < 4);
    cycles(12);

    // Random words, gaps and stalls on both instances
    rand_se[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(0, 8'($urandom), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) cycles($urandom_range(1, 4));
    end
    lv[0] = 1'b0;
    rand_se[1] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(1, 8'($urandom), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) cycles($urandom_range(1, 4));
    end
    lv[1] = 1'b0;
    cycles(2);
    rand_se[0] = 1'b0;
    rand_se[1] = 1'b0;
    se[0] = 1'b1;
    se[1] = 1'b1;
    cycles(12);

    for (int k = 0; k < 2; k++) chk("drained", k, 32'(sbq[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
